pipe_ctrl_gen: RTL and testbench
================================

// Module: pipe_ctrl_gen
// PURPOSE
//  Parametrised pipeline control unit for the MIPS core. Arbitrates per-stage stall requests,
//  external bus stalls and CP0 exceptions. Produces a registered stall mask, a flush pulse and
//  a redirect PC. Sits beside the pipeline registers, feeding pc_reg, the stage regs and cp0.
//  Unlike the previous unit, an exception raised during a bus stall is latched and deferred.
//  The flush width is also configurable.
// PARAMETERS
//  NSTAGE        6             number of stall-controlled stages (bit 0 = PC, bit NSTAGE-1 = WB)
//  AW            32            PC / EPC width
//  EXC_VEC       32'hbfc00380  redirect target for all non-ERET exceptions
//  FLUSH_CYCLES  1             cycles flush is held high (>=1)
//  CNT_W         32            stall-cycle counter width
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        asynchronous, active-high reset
//  stallreq_i    in   NSTAGE   stallreq_i[i]=1: stage i requests a stall (bits 0 and NSTAGE-1 ignored)
//  mem_stall_i   in   1        bus/cache not ready; freeze all stages except WB
//  excepttype_i  in   32       exception code from MEM; 0 = none, 32'he = ERET
//  cp0_epc_i     in   AW       current EPC from cp0
//  stat_clr_i    in   1        synchronous clear of stall_cnt_o
//  stall_o       out  NSTAGE   stall_o[k]=1 freezes stage k
//  flush_o       out  1        flush all pipeline registers
//  redirect_o    out  1        one-cycle strobe: new_pc_o valid, PC must load it
//  new_pc_o      out  AW       redirect target
//  pend_o        out  1        exception latched, waiting for mem_stall_i to drop
//  stall_cnt_o   out  CNT_W    cycles with stall_o!=0, saturating
// BEHAVIOUR
//  - Outputs registered on rising clk; latency 1 cycle from input to output.
//  - Reset: stall_o=0, flush_o=0, redirect_o=0, new_pc_o=0, pend_o=0, stall_cnt_o=0; state RUN.
//  - Stall mask: let h = highest set index of stallreq_i[NSTAGE-2:1].
//    mask = ones in bits [h:0], zeros above; no request -> 0.
//    mem_stall_i forces mask = bits [NSTAGE-2:0] set.
//  - Target: excepttype_i==32'he -> cp0_epc_i; any other nonzero code -> EXC_VEC.
//  - FSM states RUN, PEND, FLUSH; priority within RUN is the order listed below:
//    RUN, exc!=0 and mem_stall_i: latch code and EPC, go PEND, stall_o=bus mask, pend_o=1, flush_o=0.
//    RUN, exc!=0 and no mem stall: go FLUSH, flush_o=1, redirect_o=1, new_pc_o=target, stall_o=0.
//    RUN, otherwise: stall_o=mask, flush_o=0, redirect_o=0, new_pc_o=0.
//    PEND: hold bus mask while mem_stall_i=1; new exceptions and stallreq_i are ignored.
//      When mem_stall_i=0, go FLUSH using the latched code and EPC (latched EPC, not live);
//      pend_o drops in the same cycle flush_o rises.
//    FLUSH: flush_o=1 for FLUSH_CYCLES consecutive cycles; new_pc_o held.
//      redirect_o is high on the first cycle only; stall_o=0.
//      excepttype_i, stallreq_i and mem_stall_i are ignored throughout.
//      After the last cycle, return to RUN and evaluate inputs normally on the next edge.
//  - Back-to-back: an exception present on the first RUN cycle after FLUSH starts a new flush.
//  - stall_cnt_o: +1 each cycle the registered stall_o!=0; holds at 2^CNT_W-1.
//    stat_clr_i sets it to 0 and takes priority over the increment.
//  - Reset asserted in any state returns the FSM to RUN immediately and drops the latched exception.
// TESTING
//  1 stallreq_i=6'b001000 (EX), no exc -> next cycle stall_o=6'b001111, flush_o=0.
//  2 stallreq_i=6'b000100|6'b001000 -> highest wins: stall_o=6'b001111.
//    mem_stall_i=1 also -> stall_o=6'b011111.
//  3 excepttype_i=32'h8 with mem idle -> 1 cycle later: flush_o=1, redirect_o=1, new_pc_o=32'hbfc00380.
//    With FLUSH_CYCLES=3: flush_o high 3 cycles, redirect_o high 1 cycle.
//  4 mem_stall_i=1 for 5 cycles; excepttype_i=32'he, cp0_epc_i=32'hbfc01234 on cycle 1 only,
//    EPC changed afterwards -> pend_o=1, stall_o=6'b011111 during the bus stall.
//    After mem_stall_i drops: flush_o=1, new_pc_o=32'hbfc01234.
//  5 During FLUSH, apply excepttype_i=32'h4 and stallreq_i=6'b000100 -> both ignored.
//    Exception still present after FLUSH -> second flush starts; stallreq_i then honoured.
//  6 CNT_W=4, hold a stall for 20 cycles -> stall_cnt_o=4'hf.
//    Pulse stat_clr_i while still stalling -> 0, then increments.
//    Assert rst mid-PEND -> all outputs 0 without waiting for a clk edge.

Source files
------------

// File: rtl/pipe_ctrl_gen.sv
// Pipeline control unit: arbitrates stage stall requests, bus stalls and CP0 exceptions
// into a registered stall mask, flush pulse and redirect PC. Exceptions raised during a bus stall are deferred.
module pipe_ctrl_gen #(
    parameter int              NSTAGE       = 6,
    parameter int              AW           = 32,
    parameter logic [AW-1:0]   EXC_VEC      = 32'hbfc00380,
    parameter int              FLUSH_CYCLES = 1,
    parameter int              CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq_i,
    input  logic              mem_stall_i,
    input  logic [31:0]       excepttype_i,
    input  logic [AW-1:0]     cp0_epc_i,
    input  logic              stat_clr_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic              flush_o,
    output logic              redirect_o,
    output logic [AW-1:0]     new_pc_o,
    output logic              pend_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [31:0]        ERET_CODE  = 32'he;
    localparam logic [NSTAGE-1:0]  BUS_MASK   = {1'b0, {(NSTAGE-1){1'b1}}};
    localparam int                 FCW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0]     FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_PEND,
        S_FLUSH
    } state_t;

    state_t            state_q;
    logic [NSTAGE-1:0] stall_q;
    logic              flush_q;
    logic              redirect_q;
    logic [AW-1:0]     new_pc_q;
    logic              pend_q;
    logic [31:0]       code_q;
    logic [AW-1:0]     epc_q;
    logic [FCW-1:0]    fcnt_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic [NSTAGE-1:0] req_mask_d;
    logic [AW-1:0]     live_target_d;
    logic [AW-1:0]     pend_target_d;
    logic              exc_d;
    logic              unused_req_ends;

    // A request at stage h freezes h and every earlier stage; PC and WB request bits carry no meaning.
    assign req_mask_d[NSTAGE-1] = 1'b0;
    assign req_mask_d[0]        = |stallreq_i[NSTAGE-2:1];
    generate
        for (genvar gi = 1; gi <= NSTAGE - 2; gi++) begin : g_mask
            assign req_mask_d[gi] = |stallreq_i[NSTAGE-2:gi];
        end
    endgenerate
    assign unused_req_ends = stallreq_i[0] ^ stallreq_i[NSTAGE-1];

    assign exc_d         = (excepttype_i != 32'd0);
    assign live_target_d = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VEC;
    assign pend_target_d = (code_q == ERET_CODE) ? epc_q : EXC_VEC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            stall_q    <= '0;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
            new_pc_q   <= '0;
            pend_q     <= 1'b0;
            code_q     <= '0;
            epc_q      <= '0;
            fcnt_q     <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (exc_d && mem_stall_i) begin
                        state_q    <= S_PEND;
                        code_q     <= excepttype_i;
                        epc_q      <= cp0_epc_i;
                        stall_q    <= BUS_MASK;
                        pend_q     <= 1'b1;
                        flush_q    <= 1'b0;
                        redirect_q <= 1'b0;
                        new_pc_q   <= '0;
                    end else if (exc_d) begin
                        state_q    <= S_FLUSH;
                        fcnt_q     <= FLUSH_LAST;
                        stall_q    <= '0;
                        pend_q     <= 1'b0;
                        flush_q    <= 1'b1;
                        redirect_q <= 1'b1;
                        new_pc_q   <= live_target_d;
                    end else begin
                        stall_q    <= mem_stall_i ? BUS_MASK : req_mask_d;
                        pend_q     <= 1'b0;
                        flush_q    <= 1'b0;
                        redirect_q <= 1'b0;
                        new_pc_q   <= '0;
                    end
                end
                S_PEND: begin
                    if (mem_stall_i) begin
                        stall_q <= BUS_MASK;
                        pend_q  <= 1'b1;
                    end else begin
                        // Redirect uses the EPC captured when the exception arrived, not the live one.
                        state_q    <= S_FLUSH;
                        fcnt_q     <= FLUSH_LAST;
                        stall_q    <= '0;
                        pend_q     <= 1'b0;
                        flush_q    <= 1'b1;
                        redirect_q <= 1'b1;
                        new_pc_q   <= pend_target_d;
                    end
                end
                S_FLUSH: begin
                    stall_q    <= '0;
                    redirect_q <= 1'b0;
                    if (fcnt_q == '0) begin
                        state_q  <= S_RUN;
                        flush_q  <= 1'b0;
                        new_pc_q <= '0;
                    end else begin
                        fcnt_q <= fcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_RUN;
                    stall_q    <= '0;
                    flush_q    <= 1'b0;
                    redirect_q <= 1'b0;
                    new_pc_q   <= '0;
                    pend_q     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stat_clr_i) begin
            stall_cnt_q <= '0;
        end else if ((stall_q != '0) && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_o     = stall_q;
    assign flush_o     = flush_q;
    assign redirect_o  = redirect_q;
    assign new_pc_o    = new_pc_q;
    assign pend_o      = pend_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed bench for pipe_ctrl_gen (3-cycle flush, 4-bit counter); expected outputs queued per step.
module tb_pipe_ctrl_gen;

    localparam logic [31:0] VEC = 32'hbfc00380;
    localparam logic [31:0] EPC = 32'hbfc01234;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stallreq_i;
    logic        mem_stall_i;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic        stat_clr_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] new_pc_o;
    logic        pend_o;
    logic [3:0]  stall_cnt_o;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic        redir;
        logic [31:0] pc;
        logic        pend;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_n = 0;

    pipe_ctrl_gen #(
        .NSTAGE(6), .AW(32), .EXC_VEC(32'hbfc00380), .FLUSH_CYCLES(3), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .stallreq_i(stallreq_i), .mem_stall_i(mem_stall_i),
        .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i), .stat_clr_i(stat_clr_i),
        .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o),
        .new_pc_o(new_pc_o), .pend_o(pend_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [5:0] s, input logic f, input logic r,
                        input logic [31:0] pc, input logic p);
        exp_t e;
        sb_q.push_back({s, f, r, pc, p});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        step_n++;
        chk($sformatf("step%0d stall_o", step_n), 64'(stall_o), 64'(e.stall));
        chk($sformatf("step%0d flush_o", step_n), 64'(flush_o), 64'(e.flush));
        chk($sformatf("step%0d redirect_o", step_n), 64'(redirect_o), 64'(e.redir));
        chk($sformatf("step%0d new_pc_o", step_n), 64'(new_pc_o), 64'(e.pc));
        chk($sformatf("step%0d pend_o", step_n), 64'(pend_o), 64'(e.pend));
        $display("step %0d: stall=%b flush=%b redir=%b pc=%h pend=%b cnt=%0d",
                 step_n, stall_o, flush_o, redirect_o, new_pc_o, pend_o, stall_cnt_o);
    endtask

    initial begin
        rst = 1'b1; stallreq_i = '0; mem_stall_i = 1'b0; excepttype_i = '0;
        cp0_epc_i = '0; stat_clr_i = 1'b0;
        #12;
        chk("reset stall_o", 64'(stall_o), 64'd0);
        chk("reset flush_o", 64'(flush_o), 64'd0);
        chk("reset pend_o", 64'(pend_o), 64'd0);
        chk("reset cnt", 64'(stall_cnt_o), 64'd0);
        rst = 1'b0;

        // stall mask arbitration
        stallreq_i = 6'b001000;                 step(6'b001111, 0, 0, 0, 0);
        stallreq_i = 6'b001100;                 step(6'b001111, 0, 0, 0, 0);
        mem_stall_i = 1'b1;                     step(6'b011111, 0, 0, 0, 0);
        mem_stall_i = 1'b0; stallreq_i = 6'b000010; step(6'b000011, 0, 0, 0, 0);
        stallreq_i = 6'b010000;                 step(6'b011111, 0, 0, 0, 0);
        stallreq_i = 6'b100001;                 step(6'b000000, 0, 0, 0, 0);
        stallreq_i = 6'b000000;                 step(6'b000000, 0, 0, 0, 0);

        // immediate exception, 3-cycle flush
        excepttype_i = 32'h8;                   step(0, 1, 1, VEC, 0);
        excepttype_i = 32'h0;                   step(0, 1, 0, VEC, 0);
                                                step(0, 1, 0, VEC, 0);
                                                step(0, 0, 0, 0, 0);
                                                step(0, 0, 0, 0, 0);

        // ERET during bus stall: latched EPC, deferred flush
        mem_stall_i = 1'b1; excepttype_i = 32'he; cp0_epc_i = EPC;
                                                step(6'b011111, 0, 0, 0, 1);
        excepttype_i = 32'h8; cp0_epc_i = 32'hdeadbeef; stallreq_i = 6'b001000;
                                                step(6'b011111, 0, 0, 0, 1);
        excepttype_i = 32'h0; stallreq_i = 6'b000000;
                                                step(6'b011111, 0, 0, 0, 1);
                                                step(6'b011111, 0, 0, 0, 1);
                                                step(6'b011111, 0, 0, 0, 1);
        mem_stall_i = 1'b0;                     step(0, 1, 1, EPC, 0);
                                                step(0, 1, 0, EPC, 0);
                                                step(0, 1, 0, EPC, 0);
                                                step(0, 0, 0, 0, 0);

        // inputs ignored during flush, back-to-back flush
        excepttype_i = 32'h8;                   step(0, 1, 1, VEC, 0);
        excepttype_i = 32'h4; stallreq_i = 6'b000100; mem_stall_i = 1'b1;
                                                step(0, 1, 0, VEC, 0);
        mem_stall_i = 1'b0;                     step(0, 1, 0, VEC, 0);
                                                step(0, 0, 0, 0, 0);
                                                step(0, 1, 1, VEC, 0);
        excepttype_i = 32'h0;                   step(0, 1, 0, VEC, 0);
                                                step(0, 1, 0, VEC, 0);
                                                step(0, 0, 0, 0, 0);
                                                step(6'b000111, 0, 0, 0, 0);

        // stall counter: clear, saturate, clear again
        stat_clr_i = 1'b1;                      step(6'b000111, 0, 0, 0, 0);
        chk("cnt after clr", 64'(stall_cnt_o), 64'd0);
        stat_clr_i = 1'b0;
        for (int i = 0; i < 20; i++)            step(6'b000111, 0, 0, 0, 0);
        chk("cnt saturated", 64'(stall_cnt_o), 64'hf);
        stat_clr_i = 1'b1;                      step(6'b000111, 0, 0, 0, 0);
        chk("cnt cleared", 64'(stall_cnt_o), 64'd0);
        stat_clr_i = 1'b0;                      step(6'b000111, 0, 0, 0, 0);
        chk("cnt inc1", 64'(stall_cnt_o), 64'd1);
                                                step(6'b000111, 0, 0, 0, 0);
        chk("cnt inc2", 64'(stall_cnt_o), 64'd2);

        // asynchronous reset while pending
        stallreq_i = 6'b000000; mem_stall_i = 1'b1; excepttype_i = 32'h8;
                                                step(6'b011111, 0, 0, 0, 1);
        #1 rst = 1'b1;
        #1;
        chk("async rst stall_o", 64'(stall_o), 64'd0);
        chk("async rst pend_o", 64'(pend_o), 64'd0);
        chk("async rst flush_o", 64'(flush_o), 64'd0);
        chk("async rst cnt", 64'(stall_cnt_o), 64'd0);
        mem_stall_i = 1'b0; excepttype_i = 32'h0;
        #1 rst = 1'b0;
                                                step(0, 0, 0, 0, 0);
                                                step(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
